// File: rtl/mcu_bus_window_writer.sv
// 8080-style MCU bus slave: command/data decode, backlight PWM, rectangular write window,
// and a first-word-fall-through FIFO of {address,pixel} requests toward the frame-buffer controller.
module mcu_bus_window_writer #(
  parameter int DATA_W     = 16,
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8,
  parameter int PWM_BITS   = 4,
  parameter int PWM_DIV    = 256
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              CS,
  input  logic              RS,
  input  logic              WR,
  input  logic              RD,
  inout  wire  [DATA_W-1:0] DATA,
  output logic              PWM,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [ADDR_W-1:0] px_addr,
  output logic [DATA_W-1:0] px_data,
  output logic              busy,
  output logic              win_done,
  output logic              overflow
);

  localparam int COL_W  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(PWM_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_RES - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(H_RES - 1);

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_DUTY   = 8'h01;
  localparam logic [7:0] CMD_ROW_S  = 8'h02;
  localparam logic [7:0] CMD_COL_S  = 8'h03;
  localparam logic [7:0] CMD_ROW_E  = 8'h06;
  localparam logic [7:0] CMD_COL_E  = 8'h07;
  localparam logic [7:0] CMD_MEMWR  = 8'h0F;

  // ---------------------------------------------------------------- synchroniser
  logic              r_cs_s1, r_cs_s2;
  logic              r_rs_s1, r_rs_s2;
  logic              r_wr_s1, r_wr_s2, r_wr_d;
  logic              r_rd_s1, r_rd_s2, r_rd_d;
  logic              r_rs_cap;
  logic [DATA_W-1:0] r_data_cap;

  // Strobes reset to their idle (high) level so a reset mid-strobe cannot fabricate an edge.
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_cs_s1    <= 1'b1;
      r_cs_s2    <= 1'b1;
      r_rs_s1    <= 1'b0;
      r_rs_s2    <= 1'b0;
      r_wr_s1    <= 1'b1;
      r_wr_s2    <= 1'b1;
      r_wr_d     <= 1'b1;
      r_rd_s1    <= 1'b1;
      r_rd_s2    <= 1'b1;
      r_rd_d     <= 1'b1;
      r_rs_cap   <= 1'b0;
      r_data_cap <= '0;
    end else begin
      r_cs_s1 <= CS;
      r_cs_s2 <= r_cs_s1;
      r_rs_s1 <= RS;
      r_rs_s2 <= r_rs_s1;
      r_wr_s1 <= WR;
      r_wr_s2 <= r_wr_s1;
      r_wr_d  <= r_wr_s2;
      r_rd_s1 <= RD;
      r_rd_s2 <= r_rd_s1;
      r_rd_d  <= r_rd_s2;
      if (!r_wr_s2) begin
        r_rs_cap   <= r_rs_s2;
        r_data_cap <= DATA;
      end
    end
  end

  logic w_wr_evt, w_cmd_wr, w_dat_wr, w_pix_wr, w_rd_rise;

  assign w_wr_evt  = !r_wr_d && r_wr_s2 && !r_cs_s2;
  assign w_cmd_wr  = w_wr_evt && !r_rs_cap;
  assign w_dat_wr  = w_wr_evt && r_rs_cap;
  assign w_rd_rise = !r_rd_d && r_rd_s2 && !r_cs_s2;

  // ---------------------------------------------------------------- registers and cursor
  logic [7:0]          r_cmd;
  logic [PWM_BITS-1:0] r_duty;
  logic [ROW_W-1:0]    r_row_s, r_row_e, r_cur_row;
  logic [COL_W-1:0]    r_col_s, r_col_e, r_cur_col;
  logic                r_win_done;

  logic [ROW_W-1:0] w_row_val, w_row_end;
  logic [COL_W-1:0] w_col_val, w_col_end;
  logic             w_col_at_end, w_row_at_end, w_win_busy;

  assign w_row_val = (r_data_cap > DATA_W'(V_RES - 1)) ? ROW_LAST : r_data_cap[ROW_W-1:0];
  assign w_col_val = (r_data_cap > DATA_W'(H_RES - 1)) ? COL_LAST : r_data_cap[COL_W-1:0];

  // An inverted axis collapses to a single line/column at its start value.
  assign w_row_end = (r_row_e < r_row_s) ? r_row_s : r_row_e;
  assign w_col_end = (r_col_e < r_col_s) ? r_col_s : r_col_e;

  assign w_col_at_end = (r_cur_col == w_col_end);
  assign w_row_at_end = (r_cur_row == w_row_end);
  assign w_win_busy   = (r_cur_row != r_row_s) || (r_cur_col != r_col_s);
  assign w_pix_wr     = w_dat_wr && (r_cmd == CMD_MEMWR);

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_cmd      <= CMD_STATUS;
      r_duty     <= '0;
      r_row_s    <= '0;
      r_col_s    <= '0;
      r_row_e    <= ROW_LAST;
      r_col_e    <= COL_LAST;
      r_cur_row  <= '0;
      r_cur_col  <= '0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      if (w_cmd_wr) begin
        r_cmd <= r_data_cap[7:0];
        if (r_data_cap[7:0] == CMD_MEMWR) begin
          r_cur_row <= r_row_s;
          r_cur_col <= r_col_s;
        end
      end
      if (w_dat_wr) begin
        case (r_cmd)
          CMD_DUTY: r_duty <= r_data_cap[PWM_BITS-1:0];
          CMD_ROW_S: begin
            r_row_s   <= w_row_val;
            r_cur_row <= w_row_val;
            r_cur_col <= r_col_s;
          end
          CMD_COL_S: begin
            r_col_s   <= w_col_val;
            r_cur_row <= r_row_s;
            r_cur_col <= w_col_val;
          end
          CMD_ROW_E: begin
            r_row_e   <= w_row_val;
            r_cur_row <= r_row_s;
            r_cur_col <= r_col_s;
          end
          CMD_COL_E: begin
            r_col_e   <= w_col_val;
            r_cur_row <= r_row_s;
            r_cur_col <= r_col_s;
          end
          CMD_MEMWR: begin
            if (!w_col_at_end) begin
              r_cur_col <= r_cur_col + 1'b1;
            end else begin
              r_cur_col <= r_col_s;
              if (w_row_at_end) begin
                r_cur_row  <= r_row_s;
                r_win_done <= 1'b1;
              end else begin
                r_cur_row <= r_cur_row + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign win_done = r_win_done;

  // ---------------------------------------------------------------- pixel FIFO
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr, r_rptr;
  logic              r_overflow;
  logic [ADDR_W-1:0] w_addr;
  logic [ENT_W-1:0]  w_head;
  logic              w_empty, w_full, w_deq, w_enq, w_drop;

  // Truncation to ADDR_W is intentional.
  assign w_addr  = ADDR_W'(r_cur_row) * ADDR_W'(H_RES) + ADDR_W'(r_cur_col);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_deq   = !w_empty && px_ready;
  assign w_enq   = w_pix_wr && (!w_full || w_deq);
  assign w_drop  = w_pix_wr && w_full && !w_deq;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wptr[PTR_W-1:0]] <= {w_addr, r_data_cap};
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_rd_rise && (r_cmd == CMD_STATUS)) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign w_head   = r_mem[r_rptr[PTR_W-1:0]];
  assign px_addr  = w_head[ENT_W-1:DATA_W];
  assign px_data  = w_head[DATA_W-1:0];
  assign px_valid = !w_empty;
  assign busy     = !w_empty;
  assign overflow = r_overflow;

  // ---------------------------------------------------------------- readback
  logic [DATA_W-1:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    case (r_cmd)
      CMD_STATUS: w_rd_data[3:0] = {r_overflow, w_win_busy, w_full, !w_empty};
      CMD_DUTY:   w_rd_data = DATA_W'(r_duty);
      CMD_ROW_S:  w_rd_data = DATA_W'(r_row_s);
      CMD_COL_S:  w_rd_data = DATA_W'(r_col_s);
      CMD_ROW_E:  w_rd_data = DATA_W'(r_row_e);
      CMD_COL_E:  w_rd_data = DATA_W'(r_col_e);
      CMD_MEMWR:  w_rd_data = DATA_W'(r_cur_col);
      default:    w_rd_data = '0;
    endcase
  end

  assign DATA = (!CS && !RD) ? w_rd_data : {DATA_W{1'bz}};

  // ---------------------------------------------------------------- backlight PWM
  logic [DIV_W-1:0]    r_div;
  logic [PWM_BITS-1:0] r_pcnt, r_duty_act;
  logic                r_pwm;

  // The active duty only changes at the period boundary so no glitch period is emitted.
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_div      <= DIV_RELOAD;
      r_pcnt     <= '0;
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      if (r_div == '0) begin
        r_div  <= DIV_RELOAD;
        r_pcnt <= r_pcnt + 1'b1;
        if (r_pcnt == {PWM_BITS{1'b1}}) r_duty_act <= r_duty;
      end else begin
        r_div <= r_div - 1'b1;
      end
      r_pwm <= (r_pcnt < r_duty_act);
    end
  end

  assign PWM = r_pwm;

endmodule

// File: tb/tb_mcu_bus_window_writer.sv
// Directed bench for mcu_bus_window_writer: bus writes/reads through the 8080 pins,
// FIFO output captured by a monitor and compared with hand-computed addresses.
module tb_mcu_bus_window_writer;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        CS = 1'b1, RS = 1'b0, WR = 1'b1, RD = 1'b1;
  logic        px_ready = 1'b0;
  logic        r_tb_drv = 1'b0;
  logic [15:0] r_tb_data = 16'h0000;
  wire  [15:0] DATA;
  logic        PWM, px_valid, busy, win_done, overflow;
  logic [18:0] px_addr;
  logic [15:0] px_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_win_done = 0;
  logic [18:0] q_addr[$];
  logic [15:0] q_data[$];

  assign DATA = r_tb_drv ? r_tb_data : 16'hzzzz;

  mcu_bus_window_writer dut (
    .clk(clk), .RST(RST), .CS(CS), .RS(RS), .WR(WR), .RD(RD), .DATA(DATA),
    .PWM(PWM), .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr),
    .px_data(px_data), .busy(busy), .win_done(win_done), .overflow(overflow)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (px_valid && px_ready) begin
      q_addr.push_back(px_addr);
      q_data.push_back(px_data);
    end
    if (win_done) n_win_done++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic rs, input logic [15:0] d);
    CS = 1'b0; RS = rs; r_tb_data = d; r_tb_drv = 1'b1;
    tick(1);
    WR = 1'b0;
    tick(4);
    WR = 1'b1;
    tick(4);
    r_tb_drv = 1'b0; CS = 1'b1;
    tick(2);
  endtask

  task automatic bus_read(output logic [15:0] d);
    r_tb_drv = 1'b0; CS = 1'b0; RD = 1'b0;
    tick(3);
    d = DATA;
    RD = 1'b1;
    tick(4);
    CS = 1'b1;
    tick(2);
  endtask

  task automatic set_reg(input logic [7:0] cmd, input logic [15:0] val);
    bus_write(1'b0, {8'h00, cmd});
    bus_write(1'b1, val);
  endtask

  initial begin
    logic [15:0] d;
    int n_high;
    int j;

    // reset: bus released, outputs idle
    r_tb_drv = 1'b1; r_tb_data = 16'h5A3C;
    tick(5);
    chk_eq("rst_pwm", PWM, 0);
    chk_eq("rst_px_valid", px_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_overflow", overflow, 0);
    chk_eq("rst_win_done", win_done, 0);
    chk_eq("rst_data_released", DATA, 16'h5A3C);
    r_tb_drv = 1'b0;
    RST = 1'b1;
    tick(2);
    bus_read(d);
    chk_eq("rst_status", d, 16'h0000);
    n_high = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (PWM) n_high++;
    end
    chk_eq("pwm_duty0_high", n_high, 0);

    // PWM duty 2 of 16
    set_reg(8'h01, 16'h0002);
    bus_read(d);
    chk_eq("duty_readback", d, 16'h0002);
    tick(8300);
    n_high = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (PWM) n_high++;
    end
    chk_eq("pwm_duty2_high", n_high, 512);

    // 10x10 window in the bottom-right corner, 101 pixels streamed
    px_ready = 1'b1;
    q_addr.delete(); q_data.delete(); n_win_done = 0;
    set_reg(8'h02, 16'd470);
    set_reg(8'h06, 16'd479);
    set_reg(8'h03, 16'd790);
    set_reg(8'h07, 16'd799);
    bus_write(1'b0, 16'h000F);
    for (int i = 0; i < 101; i++) bus_write(1'b1, 16'h001F + 16'(i));
    tick(5);
    chk_eq("win_count", q_addr.size(), 101);
    for (int i = 0; i < 101 && i < q_addr.size(); i++) begin
      j = i % 100;
      chk_eq($sformatf("win_addr[%0d]", i), q_addr[i], (470 + j / 10) * 800 + 790 + j % 10);
      chk_eq($sformatf("win_data[%0d]", i), q_data[i], 16'h001F + 16'(i));
    end
    chk_eq("win_last_addr", (q_addr.size() > 99) ? q_addr[99] : 19'h0, 479 * 800 + 799);
    chk_eq("win_done_once", n_win_done, 1);

    // overflow: 10 pixels into an 8-deep FIFO with no consumer
    px_ready = 1'b0;
    q_addr.delete(); q_data.delete();
    bus_write(1'b0, 16'h000F);
    for (int i = 0; i < 10; i++) bus_write(1'b1, 16'h0100 + 16'(i));
    chk_eq("ovf_busy", busy, 1);
    chk_eq("ovf_valid", px_valid, 1);
    chk_eq("ovf_flag", overflow, 1);
    chk_eq("ovf_head_addr", px_addr, 470 * 800 + 790);
    chk_eq("ovf_head_data", px_data, 16'h0100);
    bus_write(1'b0, 16'h0000);
    bus_read(d);
    chk_eq("ovf_status1", d, 16'h000F);
    bus_read(d);
    chk_eq("ovf_status2", d, 16'h0007);
    chk_eq("ovf_cleared", overflow, 0);
    px_ready = 1'b1;
    tick(12);
    chk_eq("ovf_drain_count", q_addr.size(), 8);
    chk_eq("ovf_drain_last_addr", (q_addr.size() > 7) ? q_addr[7] : 19'h0, 470 * 800 + 797);
    chk_eq("ovf_drain_last_data", (q_data.size() > 7) ? q_data[7] : 16'h0, 16'h0107);
    chk_eq("ovf_drain_busy", busy, 0);

    // col_s clamps to 799, col_e below start collapses to a single column
    q_addr.delete(); q_data.delete();
    set_reg(8'h02, 16'd0);
    set_reg(8'h06, 16'd479);
    set_reg(8'h03, 16'd900);
    set_reg(8'h07, 16'd10);
    bus_write(1'b0, 16'h0003);
    bus_read(d);
    chk_eq("clamp_col_s", d, 16'd799);
    bus_write(1'b0, 16'h000F);
    for (int i = 0; i < 3; i++) bus_write(1'b1, 16'h0200 + 16'(i));
    tick(5);
    chk_eq("col1_count", q_addr.size(), 3);
    for (int i = 0; i < 3 && i < q_addr.size(); i++)
      chk_eq($sformatf("col1_addr[%0d]", i), q_addr[i], i * 800 + 799);

    // reset with pixels queued
    px_ready = 1'b0;
    set_reg(8'h02, 16'd100);
    bus_write(1'b0, 16'h000F);
    for (int i = 0; i < 5; i++) bus_write(1'b1, 16'h0250 + 16'(i));
    chk_eq("rst2_busy_before", busy, 1);
    RST = 1'b0;
    tick(5);
    chk_eq("rst2_busy", busy, 0);
    chk_eq("rst2_valid", px_valid, 0);
    chk_eq("rst2_pwm", PWM, 0);
    RST = 1'b1;
    tick(2);
    bus_write(1'b0, 16'h000F);
    bus_read(d);
    chk_eq("rst2_cursor_col", d, 16'd0);
    bus_write(1'b0, 16'h0002);
    bus_read(d);
    chk_eq("rst2_row_s", d, 16'd0);
    bus_write(1'b0, 16'h0006);
    bus_read(d);
    chk_eq("rst2_row_e", d, 16'd479);
    bus_write(1'b0, 16'h0007);
    bus_read(d);
    chk_eq("rst2_col_e", d, 16'd799);
    px_ready = 1'b1;
    q_addr.delete(); q_data.delete();
    bus_write(1'b0, 16'h000F);
    bus_write(1'b1, 16'h0300);
    bus_write(1'b1, 16'h0301);
    tick(5);
    chk_eq("rst2_count", q_addr.size(), 2);
    chk_eq("rst2_addr0", (q_addr.size() > 0) ? q_addr[0] : 19'h7FFFF, 0);
    chk_eq("rst2_addr1", (q_addr.size() > 1) ? q_addr[1] : 19'h7FFFF, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
